// File: rtl/reg_file_rename_if.sv
// Operand-lookup / rename / commit bundle between the decoder, the ROB and
// the architectural register file. The master side is the decoder plus the
// ROB commit port. The slave side is the register file itself.
interface reg_file_rename_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ROB_POS_W  = 4
);
  logic                  rdy;
  logic                  rollback;
  logic                  issue;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [ROB_POS_W-1:0]  issue_rob_pos;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] reg_rd;
  logic [31:0]           reg_val;
  logic [ROB_POS_W-1:0]  commit_rob_pos;
  logic [REG_ADDR_W-1:0] rs1;
  logic [31:0]           rs1_val;
  logic                  rs1_busy;
  logic [ROB_POS_W-1:0]  rs1_rob_pos;
  logic [REG_ADDR_W-1:0] rs2;
  logic [31:0]           rs2_val;
  logic                  rs2_busy;
  logic [ROB_POS_W-1:0]  rs2_rob_pos;

  modport master (
    output rdy, rollback, issue, issue_rd, issue_rob_pos,
    output reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    input  rs1_val, rs1_busy, rs1_rob_pos, rs2_val, rs2_busy, rs2_rob_pos
  );

  modport slave (
    input  rdy, rollback, issue, issue_rd, issue_rob_pos,
    input  reg_write, reg_rd, reg_val, commit_rob_pos, rs1, rs2,
    output rs1_val, rs1_busy, rs1_rob_pos, rs2_val, rs2_busy, rs2_rob_pos
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// The decoder renames a destination to a ROB slot at issue time.
// The ROB commit port writes values back and clears the rename when the tag
// still matches. Two zero-latency source lookups return either a value or
// the ROB slot that will produce that value. A commit that lands in the same
// cycle as a lookup is bypassed straight to the lookup result.
module reg_file_rename #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ROB_POS_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_rename_if.slave  bus
);

  typedef struct packed {
    logic [31:0]          val;
    logic                 busy;
    logic [ROB_POS_W-1:0] pos;
  } query_t;

  logic [31:0]          val_q [REG_NUM];
  logic [31:0]          val_d [REG_NUM];
  logic [ROB_POS_W-1:0] tag_q [REG_NUM];
  logic [ROB_POS_W-1:0] tag_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [REG_NUM-1:0]   busy_d;

  query_t q1_s;
  query_t q2_s;

  // Resolve one source lookup against the held state and the in-flight commit.
  // The lookup uses the state as it was before any issue in this cycle, so an
  // instruction that reads its own destination sees the older producer.
  function automatic query_t lookup(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [31:0]           val,
    input logic                  busy,
    input logic [ROB_POS_W-1:0]  tag,
    input logic                  wr,
    input logic [REG_ADDR_W-1:0] wr_rd,
    input logic [31:0]           wr_val,
    input logic [ROB_POS_W-1:0]  wr_pos,
    input logic                  flush
  );
    query_t r;
    logic   hit;
    hit    = busy & wr & (wr_rd == rs) & (wr_pos == tag);
    r.val  = val;
    r.busy = 1'b0;
    r.pos  = tag;
    if (rs == {REG_ADDR_W{1'b0}}) begin
      r.val = 32'h0000_0000;
      r.pos = {ROB_POS_W{1'b0}};
    end else if (!busy) begin
      r.val = val;
    end else if (flush) begin
      // A flush clears every rename, so nothing is reported as pending.
      r.val = hit ? wr_val : val;
    end else if (hit) begin
      r.val = wr_val;
    end else begin
      r.busy = 1'b1;
    end
    return r;
  endfunction

  // Next-state logic: commit writes the value, and rollback or issue then decides busy and tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (bus.rdy) begin
      if (bus.reg_write && (bus.reg_rd != {REG_ADDR_W{1'b0}})) begin
        val_d[bus.reg_rd] = bus.reg_val;
        // A newer rename of this register has a different tag and stays pending.
        if (busy_q[bus.reg_rd] && (tag_q[bus.reg_rd] == bus.commit_rob_pos)) begin
          busy_d[bus.reg_rd] = 1'b0;
        end else begin
          busy_d[bus.reg_rd] = busy_q[bus.reg_rd];
        end
      end else begin
        val_d = val_q;
      end
      // The issue is applied after the commit, so the issue sets busy and tag when both target the same register.
      if (bus.rollback) begin
        busy_d = {REG_NUM{1'b0}};
      end else if (bus.issue && (bus.issue_rd != {REG_ADDR_W{1'b0}})) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_rob_pos;
      end else begin
        tag_d = tag_q;
      end
    end else begin
      val_d  = val_q;
      tag_d  = tag_q;
      busy_d = busy_q;
    end
  end

  // State registers with synchronous reset that drops every pending rename.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= 32'h0000_0000;
        tag_q[i] <= {ROB_POS_W{1'b0}};
      end
      busy_q <= {REG_NUM{1'b0}};
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Source lookups are combinational on the held state and the commit bypass.
  always_comb begin
    q1_s = lookup(bus.rs1, val_q[bus.rs1], busy_q[bus.rs1], tag_q[bus.rs1],
                  bus.reg_write, bus.reg_rd, bus.reg_val, bus.commit_rob_pos, bus.rollback);
    q2_s = lookup(bus.rs2, val_q[bus.rs2], busy_q[bus.rs2], tag_q[bus.rs2],
                  bus.reg_write, bus.reg_rd, bus.reg_val, bus.commit_rob_pos, bus.rollback);
    bus.rs1_val     = q1_s.val;
    bus.rs1_busy    = q1_s.busy;
    bus.rs1_rob_pos = q1_s.pos;
    bus.rs2_val     = q2_s.val;
    bus.rs2_busy    = q2_s.busy;
    bus.rs2_rob_pos = q2_s.pos;
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Scoreboard bench for reg_file_rename. The driver applies one cycle of stimulus.
// It predicts the lookup results from a behavioural register model and queues
// them. The monitor pops the queue on the falling edge and compares the
// prediction with the DUT outputs.
module tb_reg_file_rename;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_rename_if bus ();

  reg_file_rename dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model: committed value, pending flag and producing slot per register.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_tag  [32];

  typedef struct {
    logic [31:0] v1;
    bit          b1;
    logic [3:0]  p1;
    bit          z1;
    logic [31:0] v2;
    bit          b2;
    logic [3:0]  p2;
    bit          z2;
  } exp_t;

  exp_t sbq [$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Predict one lookup from the rules for value, pending state and same-cycle commit.
  function automatic void predict(input int rs, input bit wr, input int wrd, input logic [31:0] wv,
                                  input int cp, input bit rb,
                                  output logic [31:0] v, output bit b, output logic [3:0] p);
    bit retiring;
    if (rs == 0) begin
      v = 32'h0; b = 1'b0; p = 4'h0;
    end else begin
      retiring = m_busy[rs] && wr && (wrd == rs) && (cp == int'(m_tag[rs]));
      v = retiring ? wv : m_val[rs];
      b = m_busy[rs] && !retiring && !rb;
      p = m_tag[rs];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs. Optionally queue the predicted lookup results, then advance the model.
  task automatic step(input bit r, input bit ry, input bit rb,
                      input bit iss, input int ird, input int ipos,
                      input bit wr, input int wrd, input logic [31:0] wv, input int cp,
                      input int s1, input int s2, input bit chk);
    exp_t x;
    @(posedge clk);
    #1;
    rst                = r;
    bus.rdy            = ry;
    bus.rollback       = rb;
    bus.issue          = iss;
    bus.issue_rd       = 5'(ird);
    bus.issue_rob_pos  = 4'(ipos);
    bus.reg_write      = wr;
    bus.reg_rd         = 5'(wrd);
    bus.reg_val        = wv;
    bus.commit_rob_pos = 4'(cp);
    bus.rs1            = 5'(s1);
    bus.rs2            = 5'(s2);
    if (chk) begin
      predict(s1, wr, wrd, wv, cp, rb, x.v1, x.b1, x.p1);
      predict(s2, wr, wrd, wv, cp, rb, x.v2, x.b2, x.p2);
      x.z1 = (s1 == 0);
      x.z2 = (s2 == 0);
      sbq.push_back(x);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'h0; m_busy[i] = 1'b0; m_tag[i] = 4'h0;
      end
    end else if (ry) begin
      if (wr && wrd != 0) begin
        m_val[wrd] = wv;
        if (m_busy[wrd] && int'(m_tag[wrd]) == cp) m_busy[wrd] = 1'b0;
      end
      if (rb) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (iss && ird != 0) begin
        m_busy[ird] = 1'b1;
        m_tag[ird]  = 4'(ipos);
      end
    end
  endtask

  // Monitor: compare each queued prediction against the outputs in the middle of the cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("rs1_val",  bus.rs1_val, e.v1);
      check("rs1_busy", {31'h0, bus.rs1_busy}, {31'h0, e.b1});
      if (e.b1 || e.z1) check("rs1_rob_pos", {28'h0, bus.rs1_rob_pos}, {28'h0, e.p1});
      check("rs2_val",  bus.rs2_val, e.v2);
      check("rs2_busy", {31'h0, bus.rs2_busy}, {31'h0, e.b2});
      if (e.b2 || e.z2) check("rs2_rob_pos", {28'h0, bus.rs2_rob_pos}, {28'h0, e.p2});
    end
  end

  initial begin
    int rd_i, cp_i, s1_i, s2_i;
    rst = 1'b1;
    bus.rdy = 1'b0; bus.rollback = 1'b0; bus.issue = 1'b0; bus.issue_rd = 5'd0;
    bus.issue_rob_pos = 4'd0; bus.reg_write = 1'b0; bus.reg_rd = 5'd0; bus.reg_val = 32'h0;
    bus.commit_rob_pos = 4'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;

    // Reset, then lookups of an ordinary register and of x0.
    step(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0, 1);

    // Rename x3 to slot 7, then commit it with a same-cycle bypass.
    step(0, 1, 0, 1, 3, 7, 0, 0, 32'h0, 0, 3, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 3, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1, 3, 32'hDEADBEEF, 7, 3, 3, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 3, 0, 1);

    // Double rename of x4: the older commit must not clear the newer rename.
    step(0, 1, 0, 1, 4, 2, 0, 0, 32'h0, 0, 0, 4, 1);
    step(0, 1, 0, 1, 4, 5, 0, 0, 32'h0, 0, 0, 4, 1);
    step(0, 1, 0, 0, 0, 0, 1, 4, 32'h11, 2, 0, 4, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 4, 1);
    step(0, 1, 0, 0, 0, 0, 1, 4, 32'h44, 5, 4, 4, 1);

    // Commit and issue to x6 in the same cycle: the issue sets busy and tag.
    step(0, 1, 0, 1, 6, 9, 1, 6, 32'h22, 1, 6, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 6, 0, 1);

    // Rollback together with a commit write and an ignored issue.
    step(0, 1, 0, 1, 1, 10, 0, 0, 32'h0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 2, 11, 0, 0, 32'h0, 0, 1, 0, 1);
    step(0, 1, 0, 1, 10, 12, 0, 0, 32'h0, 0, 1, 2, 1);
    step(0, 1, 1, 1, 2, 3, 1, 1, 32'h80, 0, 1, 10, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 2, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 10, 0, 1);

    // x0 ignores writes and renames. A stalled issue has no effect.
    step(0, 1, 0, 1, 0, 6, 1, 0, 32'h55, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 8, 4, 1, 8, 32'h99, 0, 8, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 8, 0, 1);

    // A reset in the middle of operation drops the pending renames.
    step(0, 1, 0, 1, 5, 13, 1, 3, 32'h77, 0, 5, 3, 1);
    step(1, 1, 0, 1, 7, 1, 0, 0, 32'h0, 0, 5, 3, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 3, 1);

    // Random traffic on a small register window so that renames collide often.
    for (int n = 0; n < 3000; n++) begin
      rd_i = $urandom_range(0, 7);
      cp_i = ($urandom_range(0, 1) == 1) ? int'(m_tag[rd_i]) : int'($urandom_range(0, 15));
      s1_i = ($urandom_range(0, 1) == 1) ? rd_i : int'($urandom_range(0, 7));
      s2_i = $urandom_range(0, 7);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 2) != 0), $urandom_range(0, 7), $urandom_range(0, 15),
           ($urandom_range(0, 1) == 1), rd_i, $urandom(), cp_i,
           s1_i, s2_i, 1);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
